encode_round_stream: RTL and testbench

ENCODE_ROUND_STREAM -- requirements
Module: encode_round_stream

---
 rtl/encode_pkg.sv | 18 +
 rtl/encode_round_stream_if.sv | 36 +++
 rtl/encode_mulacc.sv | 21 ++
 rtl/encode_round_stream.sv | 213 +++++++++++++++++++++
 tb/tb_encode_round_stream.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/encode_pkg.sv
// Shared definitions for the round encoder: FSM states, byte width and the
// default byte-emission threshold.
package encode_pkg;

  localparam int BYTE_W        = 8;
  localparam int LIMIT_DEFAULT = 16384;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD0,
    ST_LOAD1,
    ST_MUL,
    ST_EMIT,
    ST_PUSH,
    ST_DONE
  } state_e;

endpackage

// File: rtl/encode_round_stream_if.sv
// Stream bundle for the round encoder: residue input, emitted bytes and
// next-round residues. The slave modport is the encoder side.
interface encode_round_stream_if
  import encode_pkg::*;
#(
  parameter int D_SIZE = 14
) ();

  // Every stream uses strict valid/ready: a transfer happens on a posedge where
  // valid and ready are both high; a raised valid and its payload stay
  // constant until that transfer, and ready may never wait on valid dropping.
  logic              in_valid;
  logic              in_ready;
  logic [D_SIZE-1:0] in_data;
  logic              in_last;

  logic              out_valid;
  logic              out_ready;
  logic [BYTE_W-1:0] out_byte;

  logic              nx_valid;
  logic              nx_ready;
  logic [D_SIZE-1:0] nx_data;
  logic              nx_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready, nx_ready,
    output in_ready, out_valid, out_byte, nx_valid, nx_data, nx_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready, nx_ready,
    input  in_ready, out_valid, out_byte, nx_valid, nx_data, nx_last
  );

endinterface

// File: rtl/encode_mulacc.sv
// Combinational pair combiner: r = r0 + r1*mp and m = m0*mp, both carried at
// twice the modulus width.
module encode_mulacc #(
  parameter int D_SIZE  = 14,
  parameter int M_WIDTH = 14
) (
  input  logic [D_SIZE-1:0]    r0,
  input  logic [D_SIZE-1:0]    r1,
  input  logic [M_WIDTH-1:0]   mp,
  input  logic [M_WIDTH-1:0]   m0,
  output logic [2*M_WIDTH-1:0] r,
  output logic [2*M_WIDTH-1:0] m
);

  localparam int PW = 2 * M_WIDTH;

  // The caller keeps moduli below 2^M_WIDTH, so neither result overflows PW.
  assign r = PW'(r0) + PW'(r1) * PW'(mp);
  assign m = PW'(m0) * PW'(mp);

endmodule

// File: rtl/encode_round_stream.sv
// One round of residue-pair encoding: combine pairs, emit low bytes while the
// modulus is large, forward the reduced residue. ENCODE_FINAL_ROUND_EN adds
// the final_round input for single-element last rounds.
module encode_round_stream
  import encode_pkg::*;
#(
  parameter int D_SIZE  = 14,
  parameter int M_WIDTH = 14,
  parameter int LIMIT   = LIMIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [M_WIDTH-1:0]   m0,
  input  logic [M_WIDTH-1:0]   mlast,
`ifdef ENCODE_FINAL_ROUND_EN
  input  logic                 final_round,
`endif
  encode_round_stream_if.slave bus,
  output logic [M_WIDTH-1:0]   nx_m0,
  output logic [M_WIDTH-1:0]   nx_mlast,
  output logic                 busy,
  output logic                 done,
  output state_e               fsm_state
);

  localparam int PW = 2 * M_WIDTH;
  localparam logic [PW-1:0] LIMIT_W = PW'(LIMIT);

  state_e state_q, state_d;

  logic [PW-1:0]      r_q, m_q;
  logic [D_SIZE-1:0]  r0_q, r1_q;
  logic [M_WIDTH-1:0] m0_q, mlast_q;
  logic               last_q, is_pair_q, first_seen_q;
  logic               final_q, tail_fin;

  logic [PW-1:0]      prod_r, prod_m;
  logic [M_WIDTH-1:0] mp;
  logic [PW:0]        m_sum;
  logic [PW-1:0]      m_shift, r_shift;
  logic               in_fire, out_fire, nx_fire;

`ifdef ENCODE_FINAL_ROUND_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      final_q <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      final_q <= final_round;
    end
  end
`else
  assign final_q = 1'b0;
`endif

  // A lone final element of a final round drains down to m <= 1 instead.
  assign tail_fin = final_q & ~is_pair_q;

  function automatic logic want_emit(input logic [PW-1:0] mv, input logic fin);
    if (fin) return mv > PW'(1);
    return mv >= LIMIT_W;
  endfunction

  assign mp = last_q ? mlast_q : m0_q;

  encode_mulacc #(
    .D_SIZE (D_SIZE),
    .M_WIDTH(M_WIDTH)
  ) u_mulacc (
    .r0(r0_q),
    .r1(r1_q),
    .mp(mp),
    .m0(m0_q),
    .r (prod_r),
    .m (prod_m)
  );

  // Ceiling divide of m by 256 after a byte leaves.
  assign m_sum   = {1'b0, m_q} + (PW + 1)'(8'hFF);
  assign m_shift = {{(BYTE_W - 1){1'b0}}, m_sum[PW:BYTE_W]};
  assign r_shift = r_q >> BYTE_W;

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;
  assign nx_fire  = bus.nx_valid & bus.nx_ready;

  assign bus.out_byte = r_q[BYTE_W-1:0];
  assign bus.nx_data  = r_q[D_SIZE-1:0];
  assign bus.nx_last  = last_q;
  assign fsm_state    = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.nx_valid  = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD0;
      end
      ST_LOAD0: begin
        busy         = 1'b1;
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          if (!bus.in_last)  state_d = ST_LOAD1;
          else if (final_q)  state_d = want_emit(PW'(mlast_q), 1'b1) ? ST_EMIT : ST_DONE;
          else               state_d = ST_PUSH;
        end
      end
      ST_LOAD1: begin
        busy         = 1'b1;
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = ST_MUL;
      end
      ST_MUL: begin
        busy    = 1'b1;
        state_d = want_emit(prod_m, 1'b0) ? ST_EMIT : ST_PUSH;
      end
      ST_EMIT: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        // Look ahead at the reduced m so the last byte leaves EMIT directly.
        if (bus.out_ready) begin
          if (want_emit(m_shift, tail_fin)) state_d = ST_EMIT;
          else if (tail_fin)                state_d = ST_DONE;
          else                              state_d = ST_PUSH;
        end
      end
      ST_PUSH: begin
        busy         = 1'b1;
        bus.nx_valid = 1'b1;
        if (bus.nx_ready) state_d = last_q ? ST_DONE : ST_LOAD0;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q          <= '0;
      m_q          <= '0;
      r0_q         <= '0;
      r1_q         <= '0;
      m0_q         <= '0;
      mlast_q      <= '0;
      last_q       <= 1'b0;
      is_pair_q    <= 1'b0;
      first_seen_q <= 1'b0;
      nx_m0        <= '0;
      nx_mlast     <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            m0_q         <= m0;
            mlast_q      <= mlast;
            first_seen_q <= 1'b0;
          end
        end
        ST_LOAD0: begin
          if (in_fire) begin
            r0_q      <= bus.in_data;
            last_q    <= bus.in_last;
            is_pair_q <= ~bus.in_last;
            if (bus.in_last) begin
              r_q <= PW'(bus.in_data);
              m_q <= PW'(mlast_q);
            end
          end
        end
        ST_LOAD1: begin
          if (in_fire) begin
            r1_q   <= bus.in_data;
            last_q <= bus.in_last;
          end
        end
        ST_MUL: begin
          r_q <= prod_r;
          m_q <= prod_m;
        end
        ST_EMIT: begin
          if (out_fire) begin
            r_q <= r_shift;
            m_q <= m_shift;
          end
        end
        ST_PUSH: begin
          // m is fully reduced here, so it fits the next-round modulus width.
          if (nx_fire) begin
            if (is_pair_q && !first_seen_q) begin
              nx_m0        <= m_q[M_WIDTH-1:0];
              first_seen_q <= 1'b1;
            end
            if (last_q) nx_mlast <= m_q[M_WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_encode_round_stream.sv
// Directed bench for encode_round_stream: hand-computed byte streams, next-round
// residues and moduli, back-pressure stall and mid-round reset.
module tb_encode_round_stream;
  import encode_pkg::*;

  localparam int D  = 14;
  localparam int MW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [MW-1:0] m0 = '0;
  logic [MW-1:0] mlast = '0;
`ifdef ENCODE_FINAL_ROUND_EN
  logic          final_round = 1'b0;
`endif
  logic [MW-1:0] nx_m0, nx_mlast;
  logic          busy, done;
  state_e        fsm_state;

  encode_round_stream_if #(.D_SIZE(D)) bus ();

  encode_round_stream #(
    .D_SIZE (D),
    .M_WIDTH(MW),
    .LIMIT  (16384)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .m0         (m0),
    .mlast      (mlast),
`ifdef ENCODE_FINAL_ROUND_EN
    .final_round(final_round),
`endif
    .bus        (bus),
    .nx_m0      (nx_m0),
    .nx_mlast   (nx_mlast),
    .busy       (busy),
    .done       (done),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_q[$];
  logic [14:0] exp_nx[$];
  logic [7:0]  got_b[$];
  logic [14:0] got_nx[$];
  int          busy_cnt, stall_cnt, done_cnt;
  logic        held_v = 1'b0;
  logic [7:0]  held_b;

  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (held_v) check_eq("byte_stable", bus.out_byte, held_b);
      if (bus.out_ready) begin
        got_b.push_back(bus.out_byte);
        held_v = 1'b0;
      end else begin
        stall_cnt++;
        held_v = 1'b1;
        held_b = bus.out_byte;
      end
    end else begin
      held_v = 1'b0;
    end
    if (bus.nx_valid && bus.nx_ready) got_nx.push_back({bus.nx_last, bus.nx_data});
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  end

  // ---------------- out_ready driver ----------------
  logic rdy_pat[$];
  logic rdy_default = 1'b1;

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_pat.size() > 0) begin
        if (bus.out_valid) bus.out_ready = rdy_pat.pop_front();
        else               bus.out_ready = 1'b0;
      end else begin
        bus.out_ready = rdy_default;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_sb();
    exp_q.delete();
    exp_nx.delete();
    got_b.delete();
    got_nx.delete();
    busy_cnt  = 0;
    stall_cnt = 0;
    done_cnt  = 0;
  endtask

  task automatic start_round(input logic [MW-1:0] a, input logic [MW-1:0] b);
    m0    = a;
    mlast = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [D-1:0] d, input logic l);
    int   n   = 0;
    logic acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("in_accept", acc, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int   n    = 0;
    logic seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      seen = done;
      n++;
    end
    check_eq("done_seen", seen, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic compare_sb(input string tag);
    check_eq({tag, "_byte_count"}, got_b.size(), exp_q.size());
    foreach (exp_q[i]) if (i < got_b.size()) check_eq({tag, "_byte"}, got_b[i], exp_q[i]);
    check_eq({tag, "_nx_count"}, got_nx.size(), exp_nx.size());
    foreach (exp_nx[i]) if (i < got_nx.size()) check_eq({tag, "_nx"}, got_nx[i], exp_nx[i]);
    check_eq({tag, "_done_pulses"}, done_cnt, 1);
    check_eq({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic run_basic_pair(input string tag);
    clear_sb();
    exp_q  = '{8'hDF, 8'h23};
    exp_nx = '{{1'b1, 14'd0}};
    start_round(14'd4591, 14'd4591);
    send(14'd1, 1'b0);
    send(14'd2, 1'b1);
    wait_done();
    compare_sb(tag);
    check_eq({tag, "_nx_m0"}, nx_m0, 322);
    check_eq({tag, "_nx_mlast"}, nx_mlast, 322);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.nx_ready = 1'b1;
    clear_sb();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_nx_valid", bus.nx_valid, 0);
    check_eq("rst_in_ready", bus.in_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_nx_m0", nx_m0, 0);
    check_eq("rst_nx_mlast", nx_mlast, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two elements, no back-pressure: also pins the 2+1+2+1 cycle latency.
    run_basic_pair("pair2");
    check_eq("pair2_busy_cycles", busy_cnt, 6);

    // Pair plus odd tail.
    clear_sb();
    exp_q  = '{8'hDF, 8'h23};
    exp_nx = '{{1'b0, 14'd0}, {1'b1, 14'd5}};
    start_round(14'd4591, 14'd4591);
    send(14'd1, 1'b0);
    send(14'd2, 1'b0);
    send(14'd5, 1'b1);
    wait_done();
    compare_sb("tail3");
    check_eq("tail3_nx_m0", nx_m0, 322);
    check_eq("tail3_nx_mlast", nx_mlast, 4591);

    // Same pair with out_ready 1-0-0-1.
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    run_basic_pair("stall");
    check_eq("stall_cycles", stall_cnt, 2);

    // Two full pairs, last pair uses mlast.
    clear_sb();
    exp_q  = '{8'hDF, 8'h23, 8'h03};
    exp_nx = '{{1'b0, 14'd0}, {1'b1, 14'd2}};
    start_round(14'd4591, 14'd128);
    send(14'd1, 1'b0);
    send(14'd2, 1'b0);
    send(14'd3, 1'b0);
    send(14'd4, 1'b1);
    wait_done();
    compare_sb("pair4");
    check_eq("pair4_nx_m0", nx_m0, 322);
    check_eq("pair4_nx_mlast", nx_mlast, 2296);

    // m exactly at the threshold emits one byte.
    clear_sb();
    exp_q  = '{8'h05};
    exp_nx = '{{1'b1, 14'd3}};
    start_round(14'd128, 14'd128);
    send(14'd5, 1'b0);
    send(14'd6, 1'b1);
    wait_done();
    compare_sb("at_limit");
    check_eq("at_limit_nx_m0", nx_m0, 64);
    check_eq("at_limit_nx_mlast", nx_mlast, 64);

    // m one below the threshold emits nothing.
    clear_sb();
    exp_nx = '{{1'b1, 14'd255}};
    start_round(14'd129, 14'd127);
    send(14'd1, 1'b0);
    send(14'd2, 1'b1);
    wait_done();
    compare_sb("below_limit");
    check_eq("below_limit_nx_m0", nx_m0, 16383);
    check_eq("below_limit_nx_mlast", nx_mlast, 16383);

    // Single-element round is forwarded untouched.
    clear_sb();
    exp_nx = '{{1'b1, 14'd77}};
    start_round(14'd100, 14'd200);
    send(14'd77, 1'b1);
    wait_done();
    compare_sb("single");
    check_eq("single_nx_mlast", nx_mlast, 200);
    check_eq("single_busy_cycles", busy_cnt, 2);

`ifdef ENCODE_FINAL_ROUND_EN
    // Final round, single element drains to m <= 1 with no PUSH.
    clear_sb();
    exp_q = '{8'h2C, 8'h01};
    final_round = 1'b1;
    start_round(14'd4591, 14'd1000);
    final_round = 1'b0;
    send(14'd300, 1'b1);
    wait_done();
    compare_sb("final");
`endif

    // Reset while stalled in EMIT, then rerun cleanly.
    clear_sb();
    rdy_default = 1'b0;
    start_round(14'd4591, 14'd4591);
    send(14'd1, 1'b0);
    send(14'd2, 1'b1);
    begin
      int   n    = 0;
      logic seen = 1'b0;
      while (!seen && n < 50) begin
        @(negedge clk);
        seen = bus.out_valid;
        n++;
      end
      check_eq("rst_mid_emit_reached", seen, 1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_mid_state", 32'(fsm_state), 32'(ST_IDLE));
    check_eq("rst_mid_out_valid", bus.out_valid, 0);
    check_eq("rst_mid_nx_valid", bus.nx_valid, 0);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_nx_m0", nx_m0, 0);
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    rdy_default = 1'b1;
    @(posedge clk);
    #1;
    run_basic_pair("rerun");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
